// File: rtl/multi_line_buffer.sv
// multi_line_buffer
//   Buffers NUM_TAPS-1 image lines and, for every accepted raster-order pixel,
//   emits a registered column of NUM_TAPS vertically aligned pixels along with
//   the position of the newest pixel and line/frame end markers.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   frame_start  pulse; restarts column/row counters (pixel in same cycle is (0,0))
//   in_pixel     input pixel, raster order
//   in_valid     in_pixel accepted this cycle (no backpressure)
//   out_taps     slice k = pixel k rows above the current one, slice 0 = current
//   out_valid    out_taps holds a complete column (row >= NUM_TAPS-1)
//   out_col      column of the slice-0 pixel
//   out_row      row of the slice-0 pixel
//   out_eol      last column of a line, qualified by out_valid
//   out_eof      last pixel of a frame, qualified by out_valid
module multi_line_buffer #(
    parameter int DATA_WIDTH = 24,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int NUM_TAPS   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame_start,
    input  logic [DATA_WIDTH-1:0]            in_pixel,
    input  logic                             in_valid,
    output logic [DATA_WIDTH*NUM_TAPS-1:0]   out_taps,
    output logic                             out_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]     out_col,
    output logic [$clog2(IMG_HEIGHT)-1:0]    out_row,
    output logic                             out_eol,
    output logic                             out_eof
);

    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int NMEM = NUM_TAPS - 1;

    localparam logic [CW-1:0] COL_LAST        = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST        = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FIRST_VALID = RW'(NUM_TAPS - 1);

    // line_mem[j] holds the line j+1 rows above the line being written.
    logic [DATA_WIDTH-1:0] line_mem [NMEM][IMG_WIDTH];
    logic [DATA_WIDTH-1:0] mem_rd   [NMEM];

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    logic [DATA_WIDTH*NUM_TAPS-1:0] taps_q, taps_d;
    logic                           valid_q, valid_d;
    logic [CW-1:0]                  ocol_q, ocol_d;
    logic [RW-1:0]                  orow_q, orow_d;
    logic                           eol_q, eol_d;
    logic                           eof_q, eof_d;

    always_comb begin
        // frame_start takes effect in the same cycle, so the coincident pixel is (0,0).
        cur_col = frame_start ? '0 : col_q;
        cur_row = frame_start ? '0 : row_q;

        for (int j = 0; j < NMEM; j++) begin
            mem_rd[j] = line_mem[j][cur_col];
        end

        col_d   = cur_col;
        row_d   = cur_row;
        taps_d  = taps_q;
        ocol_d  = ocol_q;
        orow_d  = orow_q;
        valid_d = 1'b0;
        eol_d   = 1'b0;
        eof_d   = 1'b0;

        if (in_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
            end

            taps_d[DATA_WIDTH-1:0] = in_pixel;
            for (int k = 1; k < NUM_TAPS; k++) begin
                taps_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_rd[k-1];
            end

            ocol_d  = cur_col;
            orow_d  = cur_row;
            valid_d = (cur_row >= ROW_FIRST_VALID);
            eol_d   = valid_d && (cur_col == COL_LAST);
            eof_d   = eol_d && (cur_row == ROW_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            taps_q  <= '0;
            valid_q <= 1'b0;
            ocol_q  <= '0;
            orow_q  <= '0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            taps_q  <= taps_d;
            valid_q <= valid_d;
            ocol_q  <= ocol_d;
            orow_q  <= orow_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
        end
    end

    // Memories are not reset; the row-count gate on out_valid hides stale data.
    // Reads above are combinational from the old contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            line_mem[0][cur_col] <= in_pixel;
            for (int j = 1; j < NMEM; j++) begin
                line_mem[j][cur_col] <= mem_rd[j-1];
            end
        end
    end

    assign out_taps  = taps_q;
    assign out_valid = valid_q;
    assign out_col   = ocol_q;
    assign out_row   = orow_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;

endmodule
